// File: rtl/v_elem_sequencer_if.sv
// rtl/v_elem_sequencer_if.sv - decode-side request and register-file control bundle for v_elem_sequencer
// Ports (slave = sequencer side):
//   in : start, vs1_in, vs2_in, vd_in, vl_in[IDX_W:0], wb_en_in
//   out: ready, rf_vs1, rf_vs2, rf_vd, rf_ele_index[IDX_W-1:0], rf_stg_en, rf_v_write,
//        alu_op_valid, busy, done, vl_err
interface v_elem_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic             ready;
  logic [4:0]       vs1_in;
  logic [4:0]       vs2_in;
  logic [4:0]       vd_in;
  logic [IDX_W:0]   vl_in;
  logic             wb_en_in;
  logic [4:0]       rf_vs1;
  logic [4:0]       rf_vs2;
  logic [4:0]       rf_vd;
  logic [IDX_W-1:0] rf_ele_index;
  logic             rf_stg_en;
  logic             rf_v_write;
  logic             alu_op_valid;
  logic             busy;
  logic             done;
  logic             vl_err;

  modport master (
    output start, vs1_in, vs2_in, vd_in, vl_in, wb_en_in,
    input  ready, rf_vs1, rf_vs2, rf_vd, rf_ele_index, rf_stg_en, rf_v_write,
           alu_op_valid, busy, done, vl_err
  );

  modport slave (
    input  start, vs1_in, vs2_in, vd_in, vl_in, wb_en_in,
    output ready, rf_vs1, rf_vs2, rf_vd, rf_ele_index, rf_stg_en, rf_v_write,
           alu_op_valid, busy, done, vl_err
  );
endinterface

// File: rtl/v_elem_sequencer.sv
// rtl/v_elem_sequencer.sv - steps one vector instruction element-by-element through the register file
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : v_elem_sequencer_if.slave (start/ready request, captured fields, register-file controls,
//           alu_op_valid, busy, done, vl_err)
// Per element: READ, ALU_LAT x WAIT, WRITE; then one DONE cycle. All outputs are Moore.
module v_elem_sequencer #(
  parameter int NUM_ELEM = 10,
  parameter int IDX_W    = 4,
  parameter int ALU_LAT  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  v_elem_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [IDX_W:0] NUM_ELEM_V = (IDX_W+1)'(NUM_ELEM);
  // Wait counter is loaded with ALU_LAT-1 and WAIT exits when it reaches zero.
  localparam logic [2:0]     WAIT_INIT  = 3'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);
  localparam logic           HAS_WAIT   = (ALU_LAT > 0);

  state_t           state_q, state_d;
  logic [4:0]       vs1_q, vs2_q, vd_q;
  logic             wb_q;
  logic             err_q;
  logic [IDX_W:0]   vl_q;
  logic [IDX_W-1:0] elem_q;
  logic [2:0]       wait_q;
  logic             aov_q;

  logic             accept;
  logic [IDX_W:0]   vl_clamped;
  logic             last_elem;

  assign accept     = (state_q == S_IDLE) && bus.start;
  assign vl_clamped = (bus.vl_in > NUM_ELEM_V) ? NUM_ELEM_V : bus.vl_in;
  // vl_q is never 0 while elements are processed, so elem+1 == vl_q marks the last one.
  assign last_elem  = (({1'b0, elem_q} + (IDX_W+1)'(1)) == vl_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (vl_clamped != '0) ? S_READ : S_DONE;
      S_READ:  state_d = HAS_WAIT ? S_WAIT : S_WRITE;
      S_WAIT:  if (wait_q == 3'd0) state_d = S_WRITE;
      S_WRITE: state_d = last_elem ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs1_q  <= '0;
      vs2_q  <= '0;
      vd_q   <= '0;
      wb_q   <= 1'b0;
      err_q  <= 1'b0;
      vl_q   <= '0;
      elem_q <= '0;
      wait_q <= '0;
      aov_q  <= 1'b0;
    end else begin
      if (accept) begin
        vs1_q  <= bus.vs1_in;
        vs2_q  <= bus.vs2_in;
        vd_q   <= bus.vd_in;
        wb_q   <= bus.wb_en_in;
        err_q  <= (bus.vl_in > NUM_ELEM_V);
        vl_q   <= vl_clamped;
        elem_q <= '0;
      end
      if (state_q == S_READ) begin
        wait_q <= WAIT_INIT;
      end else if ((state_q == S_WAIT) && (wait_q != 3'd0)) begin
        wait_q <= wait_q - 3'd1;
      end
      if ((state_q == S_WRITE) && !last_elem) begin
        elem_q <= elem_q + IDX_W'(1);
      end
      // Register-file read data appears one cycle after READ.
      aov_q <= (state_q == S_READ);
    end
  end

  assign bus.ready        = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.rf_vs1       = (state_q != S_IDLE) ? vs1_q : 5'd0;
  assign bus.rf_vs2       = (state_q != S_IDLE) ? vs2_q : 5'd0;
  assign bus.rf_vd        = (state_q != S_IDLE) ? vd_q  : 5'd0;
  assign bus.rf_ele_index = ((state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE))
                            ? elem_q : '0;
  assign bus.rf_stg_en    = (state_q == S_READ) || (state_q == S_WRITE);
  assign bus.rf_v_write   = (state_q == S_WRITE) && wb_q;
  assign bus.alu_op_valid = aov_q;
  assign bus.done         = (state_q == S_DONE);
  assign bus.vl_err       = (state_q == S_DONE) && err_q;

endmodule
